// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and defaults for the programmable serial-pattern detector.
package seq_detect_ctrl_pkg;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config, control and serial-stream signals between a host and seq_detect_ctrl.
interface seq_detect_ctrl_if
    import seq_detect_ctrl_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_err;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_bit;
    logic             busy;
    logic             match_pulse;
    logic [CNT_W-1:0] match_count;
    logic             done;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, in_valid, in_bit,
        input  cfg_ready, cfg_err, busy, match_pulse, match_count, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, in_valid, in_bit,
        output cfg_ready, cfg_err, busy, match_pulse, match_count, done
    );
endinterface

// File: rtl/seq_detect_ctrl_core.sv
// History shift register, saturating bit counter and length-masked comparator.
module seq_match_core
    import seq_detect_ctrl_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);
    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [LEN_W-1:0] nbits_q;
    logic [LEN_W-1:0] nbits_d;
    logic [PAT_W-1:0] mask;

    // Next history/count and a hit decision on the history as it will be after this bit
    always_comb begin
        hist_d  = {hist_q[PAT_W-2:0], bit_in};
        nbits_d = (nbits_q == LEN_W'(PAT_W)) ? nbits_q : nbits_q + LEN_W'(1);
        mask    = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit = shift && (nbits_d >= len) && (((hist_d ^ pattern) & mask) == '0);
    end

    // History and bit count advance only on qualified bits; clr restarts a scan
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            nbits_q <= '0;
        end else if (clr) begin
            hist_q  <= '0;
            nbits_q <= '0;
        end else if (shift) begin
            hist_q  <= hist_d;
            nbits_q <= nbits_d;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequenced controller: config latch, scan FSM, match counter and registered outputs.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic              clk,
    input logic              reset,
    seq_detect_ctrl_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

    state_t           state;
    state_t           state_d;

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] tgt_q;
    logic             loaded_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cfg_ready_q;
    logic             busy_q;
    logic             pulse_q;
    logic             done_q;
    logic             err_q;

    logic             cfg_hs_c;
    logic             len_ok_c;
    logic             go_c;
    logic             shift_c;
    logic             hit_c;
    logic             reach_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Handshake, start qualification and match bookkeeping
    always_comb begin
        cfg_hs_c  = (state == ST_IDLE) && bus.cfg_valid;
        len_ok_c  = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PAT_W));
        go_c      = (state == ST_IDLE) && bus.start && (loaded_q || (cfg_hs_c && len_ok_c));
        shift_c   = (state == ST_RUN) && bus.in_valid && !bus.abort;
        cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        reach_c   = hit_c && (tgt_q != '0) && (cnt_inc_c == tgt_q);
    end

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (go_c),
        .shift   (shift_c),
        .bit_in  (bus.in_bit),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next-state logic; abort takes priority over a completing match
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (go_c) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.abort)    state_d = ST_IDLE;
                else if (reach_c) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Config latch; an illegal length leaves the previous config untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q    <= '0;
            len_q    <= '0;
            tgt_q    <= '0;
            loaded_q <= 1'b0;
        end else if (cfg_hs_c && len_ok_c) begin
            pat_q    <= bus.cfg_pattern;
            len_q    <= bus.cfg_len;
            tgt_q    <= bus.cfg_target;
            loaded_q <= 1'b1;
        end
    end

    // Registered outputs derived from next state and this cycle's events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pulse_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cfg_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            pulse_q     <= hit_c;
            err_q       <= cfg_hs_c && !len_ok_c;
            if (go_c)       cnt_q <= '0;
            else if (hit_c) cnt_q <= cnt_inc_c;
        end
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.match_pulse = pulse_q;
    assign bus.cfg_err     = err_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed table-driven bench for seq_detect_ctrl plus a hand-written async-reset sequence.
module tb_seq_detect_ctrl;

    // Expected flag encoding: {cfg_ready, busy, match_pulse, done, cfg_err}
    localparam logic [4:0] F_IDLE  = 5'b10000;
    localparam logic [4:0] F_ERR   = 5'b10001;
    localparam logic [4:0] F_RUN   = 5'b01000;
    localparam logic [4:0] F_RUN_P = 5'b01100;
    localparam logic [4:0] F_DONE  = 5'b00110;

    typedef struct {
        string      name;
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       iv;
        logic       ib;
        logic [4:0] ef;
        logic [7:0] ec;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    vec_t vq[$];

    seq_detect_ctrl_if #(.PAT_W(8), .CNT_W(8)) bus ();

    seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string n, input logic cv, input logic [7:0] pat, input logic [3:0] len,
                       input logic [7:0] tgt, input logic st, input logic ab, input logic iv,
                       input logic ib, input logic [4:0] ef, input logic [7:0] ec);
        vec_t v;
        v.name = n; v.cv = cv; v.pat = pat; v.len = len; v.tgt = tgt;
        v.st = st; v.ab = ab; v.iv = iv; v.ib = ib; v.ef = ef; v.ec = ec;
        vq.push_back(v);
    endtask

    // Stream-only vector shorthand
    task automatic add_bit(input string n, input logic iv, input logic ib, input logic ab,
                           input logic [4:0] ef, input logic [7:0] ec);
        add(n, 1'b0, 8'h00, 4'd0, 8'h00, 1'b0, ab, iv, ib, ef, ec);
    endtask

    task automatic drive(input vec_t v);
        bus.cfg_valid   = v.cv;
        bus.cfg_pattern = v.pat;
        bus.cfg_len     = v.len;
        bus.cfg_target  = v.tgt;
        bus.start       = v.st;
        bus.abort       = v.ab;
        bus.in_valid    = v.iv;
        bus.in_bit      = v.ib;
    endtask

    task automatic check(input string name, input logic [4:0] ef, input logic [7:0] ec);
        logic [4:0] af;
        af = {bus.cfg_ready, bus.busy, bus.match_pulse, bus.done, bus.cfg_err};
        n_vec++;
        if (af !== ef || bus.match_count !== ec) begin
            n_err++;
            $display("FAIL %s: got rdy/bsy/pls/dn/err=%b count=%0d, want %b count=%0d",
                     name, af, bus.match_count, ef, ec);
        end
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check(v.name, v.ef, v.ec);
    endtask

    initial begin
        vec_t idle_v;
        n_vec = 0;
        n_err = 0;
        idle_v.name = "idle"; idle_v.cv = 0; idle_v.pat = 0; idle_v.len = 0; idle_v.tgt = 0;
        idle_v.st = 0; idle_v.ab = 0; idle_v.iv = 0; idle_v.ib = 0; idle_v.ef = F_IDLE; idle_v.ec = 0;

        // Config errors and start without config
        add("start_nocfg",   0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, F_IDLE, 0);
        add("cfg_len0",      1, 8'h0B, 4'd0, 8'd2, 0, 0, 0, 0, F_ERR,  0);
        add("start_after_e", 0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, F_IDLE, 0);
        add("cfg_len9",      1, 8'h0B, 4'd9, 8'd2, 0, 0, 0, 0, F_ERR,  0);
        // Overlap 1011, target 2; config+start same cycle, coincident bit ignored
        add("cfg_and_start", 1, 8'h0B, 4'd4, 8'd2, 1, 0, 1, 1, F_RUN,  0);
        add_bit("ov_b1", 1, 1, 0, F_RUN,   0);
        add_bit("ov_b2", 1, 0, 0, F_RUN,   0);
        add_bit("ov_b3", 1, 1, 0, F_RUN,   0);
        add_bit("ov_b4", 1, 1, 0, F_RUN_P, 1);
        add_bit("ov_b5", 1, 0, 0, F_RUN,   1);
        add_bit("ov_b6", 1, 1, 0, F_RUN,   1);
        add_bit("ov_b7", 1, 1, 0, F_DONE,  2);
        add("done_ignores",  1, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, F_IDLE, 2);
        add_bit("ov_idle", 0, 0, 0, F_IDLE, 2);
        // len=1, target 3
        add("cfg_len1",      1, 8'h01, 4'd1, 8'd3, 0, 0, 0, 0, F_IDLE, 2);
        add("start_len1",    0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, F_RUN,  0);
        add_bit("l1_b1", 1, 1, 0, F_RUN_P, 1);
        add_bit("l1_b2", 1, 1, 0, F_RUN_P, 2);
        add_bit("l1_b3", 1, 1, 0, F_DONE,  3);
        add_bit("l1_idle", 0, 0, 0, F_IDLE, 3);
        // len=8 pattern 0x05: partial history must not match on zero-filled bits
        add("cfg_05",        1, 8'h05, 4'd8, 8'd1, 0, 0, 0, 0, F_IDLE, 3);
        add("start_05",      0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, F_RUN,  0);
        add_bit("p05_b1", 1, 1, 0, F_RUN, 0);
        add_bit("p05_b2", 1, 0, 0, F_RUN, 0);
        add_bit("p05_b3", 1, 1, 0, F_RUN, 0);
        add_bit("abort_3of", 0, 0, 1, F_IDLE, 0);
        // len=8 pattern 0xA5
        add("cfg_a5",        1, 8'hA5, 4'd8, 8'd1, 0, 0, 0, 0, F_IDLE, 0);
        add("start_a5",      0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, F_RUN,  0);
        add_bit("a5_b1", 1, 1, 0, F_RUN, 0);
        add_bit("a5_b2", 1, 0, 0, F_RUN, 0);
        add_bit("a5_b3", 1, 1, 0, F_RUN, 0);
        add_bit("a5_b4", 1, 0, 0, F_RUN, 0);
        add_bit("a5_b5", 1, 0, 0, F_RUN, 0);
        add_bit("a5_b6", 1, 1, 0, F_RUN, 0);
        add_bit("a5_b7", 1, 0, 0, F_RUN, 0);
        add_bit("a5_b8", 1, 1, 0, F_DONE, 1);
        add_bit("a5_idle", 0, 0, 0, F_IDLE, 1);
        // Gaps: invalid cycles carry spoiler bits
        add("cfg_gap",       1, 8'h0B, 4'd4, 8'd1, 1, 0, 0, 0, F_RUN,  0);
        add_bit("gap_v1", 1, 1, 0, F_RUN, 0);
        add_bit("gap_x1", 0, 0, 0, F_RUN, 0);
        add_bit("gap_v2", 1, 0, 0, F_RUN, 0);
        add_bit("gap_x2", 0, 1, 0, F_RUN, 0);
        add_bit("gap_v3", 1, 1, 0, F_RUN, 0);
        add_bit("gap_x3", 0, 0, 0, F_RUN, 0);
        add_bit("gap_v4", 1, 1, 0, F_DONE, 1);
        add_bit("gap_idle", 0, 0, 0, F_IDLE, 1);
        // Abort coincident with completing bit
        add("start_ab",      0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, F_RUN,  0);
        add_bit("ab_b1", 1, 1, 0, F_RUN, 0);
        add_bit("ab_b2", 1, 0, 0, F_RUN, 0);
        add_bit("ab_b3", 1, 1, 0, F_RUN, 0);
        add_bit("ab_hit", 1, 1, 1, F_IDLE, 0);
        add_bit("ab_idle", 0, 0, 0, F_IDLE, 0);
        // target=0: count runs until abort, held afterwards
        add("cfg_t0",        1, 8'h01, 4'd1, 8'd0, 1, 0, 0, 0, F_RUN,  0);
        add_bit("t0_b1", 1, 1, 0, F_RUN_P, 1);
        add_bit("t0_b2", 1, 1, 0, F_RUN_P, 2);
        add_bit("t0_b3", 1, 0, 0, F_RUN,   2);
        add_bit("t0_b4", 1, 1, 0, F_RUN_P, 3);
        add_bit("t0_abort", 1, 1, 1, F_IDLE, 3);
        add_bit("t0_idle", 0, 0, 0, F_IDLE, 3);

        drive(idle_v);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", F_IDLE, 0);
        reset = 1'b0;

        foreach (vq[i]) apply(vq[i]);

        // Reset mid-RUN with five matches counted
        begin
            vec_t v;
            v = idle_v;
            v.name = "rst_start"; v.st = 1; v.ef = F_RUN; v.ec = 0;
            apply(v);
            for (int k = 1; k <= 5; k++) begin
                v = idle_v;
                v.name = $sformatf("rst_b%0d", k); v.iv = 1; v.ib = 1; v.ef = F_RUN_P; v.ec = 8'(k);
                apply(v);
            end
            drive(idle_v);
            #2 reset = 1'b1;
            #1 check("reset_async", F_IDLE, 0);
            @(posedge clk);
            #1 reset = 1'b0;
            v = idle_v;
            v.name = "start_after_rst"; v.st = 1; v.ef = F_IDLE; v.ec = 0;
            apply(v);
            v.name = "still_idle"; v.st = 0; v.iv = 1; v.ib = 1;
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
